// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : serial_adder_ctrl_pkg                                           |
// | Brief  : Shared state encoding, width limits and the bit-counter width   |
// |          helper for the bit-serial adder sequencer.                      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package serial_adder_ctrl_pkg;

  // Sequencer states. The encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Supported operand widths.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // The bit counter must index 0..w-1 and is never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : half_adder / full_adder_bit                                     |
// | Brief  : Purely combinational 1-bit full adder built from two half       |
// |          adders whose carries are ORed together.                         |
// | Ports  : i_a, i_b, i_cin -> o_sum, o_cout                                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;
endmodule

module full_adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_sum(w_s0),  .o_carry(w_c0));
  half_adder u_ha1 (.i_a(w_s0), .i_b(i_cin), .o_sum(o_sum), .o_carry(w_c1));

  // At most one of the two half-adder carries can be set.
  assign o_cout = w_c0 | w_c1;
endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : serial_adder_ctrl                                               |
// | Brief  : Bit-serial adder sequencer. Operands arrive over a valid/ready  |
// |          handshake, are added LSB-first through one full-adder cell      |
// |          (one bit per clock, registered carry) and the WIDTH-bit sum     |
// |          plus carry-out leave over a second valid/ready handshake.       |
// | Ports  : clk, rst_n (async, active low)                                  |
// |          in_valid/in_ready, a, b, cin      operand handshake             |
// |          out_valid/out_ready, sum, cout    result handshake              |
// |          busy                              high in RUN or DONE           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int                c_cnt_w    = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_fa_sum;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_sum_next;

  full_adder_bit u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // Partial-sum shift register. Only WIDTH-1 bits need storing: on the last
  // RUN cycle the fresh adder bit completes the word, which is then copied
  // straight into the output register.
  if (WIDTH > 1) begin : g_sum_sr
    logic [WIDTH-2:0] r_sum_sr;

    assign w_sum_next = {w_fa_sum, r_sum_sr};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum_sr <= '0;
      end else if (r_state == S_RUN) begin
        r_sum_sr <= w_sum_next[WIDTH-1:1];
      end
    end
  end else begin : g_sum_single
    assign w_sum_next = w_fa_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready rises on the first edge after reset release.
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_a_sr     <= a;
            r_b_sr     <= b;
            r_carry    <= cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + c_cnt_one;
          if (r_cnt == c_cnt_last) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_fa_cout;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
`default_nettype wire
